// File: rtl/axi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ram_pkg
// Description : Shared AXI constants, read-scheduler FSM encoding and the
//               arsize helper for the AXI RAM read path.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ram_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Beat size code: log2 of the number of bytes per data beat.
    function automatic logic [2:0] calc_arsize(input int unsigned data_width);
        logic [2:0]  v_size;
        int unsigned v_bytes;
        v_size  = 3'd0;
        v_bytes = data_width / 8;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == v_bytes) begin
                v_size = 3'(i);
            end
        end
        return v_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_ram_rd_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant with a last-grant register that is
//               updated by a strobe when the granted transfer completes.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       update_idx,
    output logic [1:0] grant
);

    logic r_last_grant;

    // Starts at 1 so that client 0 wins the first contention.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
        end else if (update) begin
            r_last_grant <= update_idx;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_ram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_ram_rd_arbiter
// Description : Shares the AXI RAM read channel between two burst clients,
//               one outstanding INCR burst at a time, round-robin granted.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ram_rd_arbiter
    import axi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [7:0]            req0_len,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [7:0]            req1_len,

    output logic [DATA_WIDTH-1:0] rd0_data,
    output logic                  rd0_valid,
    output logic                  rd0_last,
    input  logic                  rd0_ready,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic                  rd1_valid,
    output logic                  rd1_last,
    input  logic                  rd1_ready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  err
);

    localparam logic [2:0] c_arsize = calc_arsize(DATA_WIDTH);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [ID_WIDTH-1:0]   r_arid;
    logic                  r_arvalid;
    logic [7:0]            r_beat_cnt;
    logic                  r_owner;
    logic                  r_err;

    logic [1:0]            w_grant;
    logic                  w_sel;
    logic                  w_req_hs;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_cnt_zero;
    logic                  w_burst_done;
    logic                  w_beat_err;
    logic                  w_rd_last;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .resetn     (resetn),
        .req        ({req1_valid, req0_valid}),
        .update     (w_burst_done),
        .update_idx (r_owner),
        .grant      (w_grant)
    );

    assign w_sel      = w_grant[1];
    assign req0_ready = (r_state == ST_IDLE) && w_grant[0];
    assign req1_ready = (r_state == ST_IDLE) && w_grant[1];
    assign w_req_hs   = (r_state == ST_IDLE) && (w_grant != 2'b00);
    assign w_ar_hs    = (r_state == ST_ADDR) && r_arvalid && m_axi_arready;
    assign w_r_hs     = (r_state == ST_DATA) && m_axi_rvalid && m_axi_rready;
    assign w_cnt_zero = (r_beat_cnt == 8'd0);

    // A burst ends on rlast, or on the expected final beat if rlast never comes.
    assign w_burst_done = w_r_hs && (m_axi_rlast || w_cnt_zero);
    assign w_rd_last    = m_axi_rlast || (m_axi_rvalid && w_cnt_zero);

    assign w_beat_err = w_r_hs && ((m_axi_rresp != AXI_RESP_OKAY) ||
                                   (m_axi_rid != r_arid) ||
                                   (m_axi_rlast && !w_cnt_zero) ||
                                   (!m_axi_rlast && w_cnt_zero));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_req_hs)     w_next_state = ST_ADDR;
            ST_ADDR: if (w_ar_hs)      w_next_state = ST_DATA;
            ST_DATA: if (w_burst_done) w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_araddr   <= '0;
            r_arlen    <= 8'd0;
            r_arid     <= '0;
            r_arvalid  <= 1'b0;
            r_beat_cnt <= 8'd0;
            r_owner    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_araddr   <= w_sel ? req1_addr : req0_addr;
                r_arlen    <= w_sel ? req1_len  : req0_len;
                r_beat_cnt <= w_sel ? req1_len  : req0_len;
                r_arid     <= ID_WIDTH'(w_sel);
                r_owner    <= w_sel;
                r_arvalid  <= 1'b1;
            end else if (w_ar_hs) begin
                r_arvalid  <= 1'b0;
            end
            if (w_r_hs && !w_cnt_zero) begin
                r_beat_cnt <= r_beat_cnt - 8'd1;
            end
            if (w_beat_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Data routing is a pure pass-through so the R channel sees no extra latency.
    always_comb begin
        rd0_data     = m_axi_rdata;
        rd1_data     = m_axi_rdata;
        rd0_valid    = 1'b0;
        rd1_valid    = 1'b0;
        rd0_last     = 1'b0;
        rd1_last     = 1'b0;
        m_axi_rready = 1'b0;
        if (r_state == ST_DATA) begin
            if (r_owner) begin
                rd1_valid    = m_axi_rvalid;
                rd1_last     = w_rd_last;
                m_axi_rready = rd1_ready;
            end else begin
                rd0_valid    = m_axi_rvalid;
                rd0_last     = w_rd_last;
                m_axi_rready = rd0_ready;
            end
        end
    end

    assign m_axi_arid    = r_arid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = c_arsize;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = r_arvalid;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_ram_rd_arbiter
// Description : Randomised scoreboard bench with an AXI RAM stub slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ram_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_addr, req1_addr;
    logic [7:0]  req0_len, req1_len;
    logic [31:0] rd0_data, rd1_data;
    logic        rd0_valid, rd0_last, rd0_ready, rd1_valid, rd1_last, rd1_ready;
    logic [7:0]  m_axi_arid, m_axi_arlen, m_axi_rid;
    logic [15:0] m_axi_araddr;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst, m_axi_rresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        err;

    always #5 clk = ~clk;

    axi_ram_rd_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_len(req1_len),
        .rd0_data(rd0_data), .rd0_valid(rd0_valid), .rd0_last(rd0_last), .rd0_ready(rd0_ready),
        .rd1_data(rd1_data), .rd1_valid(rd1_valid), .rd1_last(rd1_last), .rd1_ready(rd1_ready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .err(err)
    );

    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    typedef struct packed { logic [15:0] addr; logic [7:0] len; logic [7:0] id; } ar_t;

    int    checks = 0;
    int    errors = 0;
    logic [31:0] mem [0:1023];
    beat_t q0[$];
    beat_t q1[$];
    ar_t   ar_q[$];
    int    grant_log[$];

    bit m_busy = 0, m_ar_done = 0, m_owner = 0, m_last_grant = 1, m_err = 0;
    int m_beat = 0, m_len = 0, rd_beats = 0;

    int inj_resp_beat = -1, inj_early_beat = -1;
    bit inj_rid = 0, inj_nolast = 0;
    int rd_mode0 = 1, rd_mode1 = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit inj_err(input int beat, input int len);
        return (beat == inj_resp_beat) || inj_rid || (beat == inj_early_beat) ||
               (inj_nolast && beat == len);
    endfunction

    function automatic void push_burst(input int c, input logic [15:0] addr, input logic [7:0] len);
        int n;
        beat_t b;
        n = (inj_early_beat >= 0 && inj_early_beat < int'(len)) ? inj_early_beat + 1 : int'(len) + 1;
        grant_log.push_back(c);
        ar_q.push_back('{addr: addr, len: len, id: 8'(c)});
        for (int i = 0; i < n; i++) begin
            b.data = mem[((int'(addr) >> 2) + i) % 1024];
            b.last = (i == n - 1);
            if (c == 0) q0.push_back(b); else q1.push_back(b);
        end
        m_busy = 1; m_ar_done = 0; m_owner = (c == 1); m_beat = 0; m_len = int'(len);
    endfunction

    // Reference model and monitor: everything sampled on the falling edge.
    initial begin
        beat_t b;
        bit e0, e1;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                q0.delete(); q1.delete(); ar_q.delete();
                m_busy = 0; m_ar_done = 0; m_last_grant = 1; m_err = 0; m_beat = 0;
            end else begin
                chk("err", err, m_err);
                e0 = 0; e1 = 0;
                if (!m_busy) begin
                    if (req0_valid && req1_valid) begin e0 = m_last_grant; e1 = !m_last_grant; end
                    else begin e0 = req0_valid; e1 = req1_valid; end
                end
                chk("req0_ready", req0_ready, e0);
                chk("req1_ready", req1_ready, e1);
                chk("arvalid", m_axi_arvalid, m_busy && !m_ar_done);
                if (m_busy && m_ar_done) begin
                    chk("rready_route", m_axi_rready, m_owner ? rd1_ready : rd0_ready);
                    chk("owner_valid", m_owner ? rd1_valid : rd0_valid, m_axi_rvalid);
                    chk("other_valid", m_owner ? rd0_valid : rd1_valid, 0);
                    chk("other_last", m_owner ? rd0_last : rd1_last, 0);
                end else begin
                    chk("rready_idle", m_axi_rready, 0);
                    chk("valid_idle", {rd0_valid, rd1_valid, rd0_last, rd1_last}, 0);
                end
                if (m_axi_arvalid) begin
                    if (ar_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ar_unexpected: actual addr %0h required no request", m_axi_araddr);
                    end else begin
                        chk("araddr", m_axi_araddr, ar_q[0].addr);
                        chk("arlen", m_axi_arlen, ar_q[0].len);
                        chk("arid", m_axi_arid, ar_q[0].id);
                        chk("arsize", m_axi_arsize, 3'd2);
                        chk("arburst", m_axi_arburst, 2'b01);
                        if (m_axi_arready) begin void'(ar_q.pop_front()); m_ar_done = 1; end
                    end
                end
                if (m_axi_rvalid && m_axi_rready && m_busy && m_ar_done) begin
                    if (inj_err(m_beat, m_len)) m_err = 1;
                    m_beat++;
                end
                if (rd0_valid && rd0_ready) begin
                    rd_beats++;
                    if (q0.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd0_unexpected: actual %0h required no beat", rd0_data);
                    end else begin
                        b = q0.pop_front();
                        chk("rd0_data", rd0_data, b.data);
                        chk("rd0_last", rd0_last, b.last);
                        if (b.last) begin m_busy = 0; m_ar_done = 0; m_last_grant = 0; end
                    end
                end
                if (rd1_valid && rd1_ready) begin
                    rd_beats++;
                    if (q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rd1_unexpected: actual %0h required no beat", rd1_data);
                    end else begin
                        b = q1.pop_front();
                        chk("rd1_data", rd1_data, b.data);
                        chk("rd1_last", rd1_last, b.last);
                        if (b.last) begin m_busy = 0; m_ar_done = 0; m_last_grant = 1; end
                    end
                end
                if (req0_valid && req0_ready) push_burst(0, req0_addr, req0_len);
                else if (req1_valid && req1_ready) push_burst(1, req1_addr, req1_len);
            end
        end
    end

    // AXI RAM stub slave with random AR/R timing and fault injection.
    initial begin
        bit s_act = 0, s_ar_hs, s_r_hs, s_nolast = 0, s_rid = 0;
        logic [15:0] n_addr, s_addr;
        logic [7:0]  n_len, n_id, s_id;
        int s_beat = 0, s_end = 0, s_resp = -1;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
        m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rid = '0;
        s_addr = '0; s_id = '0;
        forever begin
            @(negedge clk);
            s_ar_hs = m_axi_arvalid && m_axi_arready;
            s_r_hs  = m_axi_rvalid && m_axi_rready;
            n_addr = m_axi_araddr; n_len = m_axi_arlen; n_id = m_axi_arid;
            @(posedge clk); #1;
            if (!resetn) begin
                s_act = 0; m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
            end else begin
                if (s_r_hs) begin
                    if (s_beat == s_end) s_act = 0;
                    s_beat++;
                end
                if (s_ar_hs) begin
                    s_act = 1; s_addr = n_addr; s_id = n_id; s_beat = 0;
                    s_end = (inj_early_beat >= 0 && inj_early_beat < int'(n_len)) ? inj_early_beat : int'(n_len);
                    s_resp = inj_resp_beat; s_nolast = inj_nolast; s_rid = inj_rid;
                end
                if (!(m_axi_rvalid && !s_r_hs)) begin
                    if (s_act && ($urandom % 4 != 0)) begin
                        m_axi_rvalid = 1;
                        m_axi_rdata  = mem[((int'(s_addr) >> 2) + s_beat) % 1024];
                        m_axi_rlast  = (s_beat == s_end) && !s_nolast;
                        m_axi_rresp  = (s_beat == s_resp) ? 2'b10 : 2'b00;
                        m_axi_rid    = s_rid ? (s_id ^ 8'd1) : s_id;
                    end else begin
                        m_axi_rvalid = 0; m_axi_rlast = 0;
                    end
                end
                m_axi_arready = ($urandom % 3 != 0);
            end
        end
    end

    initial begin
        rd0_ready = 0; rd1_ready = 0;
        forever begin
            @(posedge clk); #1;
            case (rd_mode0)
                0: rd0_ready = ($urandom % 4 != 0);
                1: rd0_ready = 1;
                default: rd0_ready = ~rd0_ready;
            endcase
            case (rd_mode1)
                0: rd1_ready = ($urandom % 4 != 0);
                1: rd1_ready = 1;
                default: rd1_ready = ~rd1_ready;
            endcase
        end
    end

    // Called at posedge+1; holds valid until accepted, returns at posedge+1.
    task automatic send_req(input int c, input logic [15:0] addr, input logic [7:0] len);
        bit done = 0;
        int t = 0;
        if (c == 0) begin req0_valid = 1; req0_addr = addr; req0_len = len; end
        else        begin req1_valid = 1; req1_addr = addr; req1_len = len; end
        while (!done && t < 3000) begin
            @(negedge clk);
            done = (c == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
            t++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL req%0d_timeout: actual no grant required grant", c);
        end
        @(posedge clk); #1;
        if (c == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((m_busy || q0.size() != 0 || q1.size() != 0) && t < 3000) begin
            @(negedge clk); #2;
            t++;
        end
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL idle_timeout: actual busy required idle");
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        resetn = 0;
        repeat (3) begin @(posedge clk); #1; end
        resetn = 1;
        @(posedge clk); #1;
    endtask

    task automatic client_traffic(input int c, input int n);
        int gap;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            send_req(c, 16'($urandom_range(0, 1000) * 4), 8'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        int base, t;
        resetn = 1;
        req0_valid = 0; req1_valid = 0;
        req0_addr = '0; req1_addr = '0; req0_len = '0; req1_len = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[16] = 32'hDEADBEEF;
        #2 resetn = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_outputs", {m_axi_arvalid, m_axi_rready, rd0_valid, rd1_valid,
                            rd0_last, rd1_last, req0_ready, req1_ready, err}, 0);
        chk("rst_ar_fields", {m_axi_araddr, m_axi_arlen, m_axi_arid}, 0);
        resetn = 1;
        @(posedge clk); #1;

        send_req(0, 16'h0040, 8'd0);
        wait_idle();
        send_req(1, 16'h0080, 8'd1);
        wait_idle();

        grant_log.delete();
        fork
            begin send_req(0, 16'h0200, 8'd3); send_req(0, 16'h0300, 8'd3); end
            begin send_req(1, 16'h0400, 8'd3); send_req(1, 16'h0500, 8'd3); end
        join
        wait_idle();
        chk("grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("grant_order", grant_log[i], i % 2);

        rd_mode1 = 2;
        base = rd_beats;
        send_req(1, 16'h0100, 8'd7);
        wait_idle();
        chk("bp_beats", rd_beats - base, 8);

        rd_mode0 = 0; rd_mode1 = 0;
        fork
            client_traffic(0, 8);
            client_traffic(1, 8);
        join
        wait_idle();
        rd_mode0 = 1; rd_mode1 = 1;

        inj_resp_beat = 1;
        send_req(0, 16'h0600, 8'd3);
        wait_idle();
        inj_resp_beat = -1;
        repeat (2) begin @(posedge clk); #1; end
        chk("err_resp_sticky", err, 1);
        reset_dut();

        inj_early_beat = 1;
        send_req(1, 16'h0700, 8'd3);
        wait_idle();
        inj_early_beat = -1;
        chk("err_early_last", err, 1);
        send_req(0, 16'h0800, 8'd1);
        wait_idle();
        reset_dut();

        inj_rid = 1;
        send_req(0, 16'h0900, 8'd2);
        wait_idle();
        inj_rid = 0;
        chk("err_rid", err, 1);
        reset_dut();

        inj_nolast = 1;
        send_req(1, 16'h0A00, 8'd2);
        wait_idle();
        inj_nolast = 0;
        chk("err_no_last", err, 1);
        reset_dut();

        send_req(1, 16'h0B00, 8'd7);
        base = rd_beats;
        t = 0;
        while (rd_beats < base + 2 && t < 2000) begin @(negedge clk); #2; t++; end
        chk("rst_mid_progress", rd_beats >= base + 2, 1);
        resetn = 0;
        #1;
        chk("rst_mid_outputs", {m_axi_arvalid, m_axi_rready, rd0_valid, rd1_valid,
                                rd0_last, rd1_last, req0_ready, req1_ready, err}, 0);
        repeat (2) begin @(posedge clk); #1; end
        resetn = 1;
        @(posedge clk); #1;
        base = rd_beats;
        send_req(0, 16'h0040, 8'd0);
        wait_idle();
        chk("post_rst_beats", rd_beats - base, 1);

        chk("q_empty", q0.size() + q1.size() + ar_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
